// File: rtl/pong_pkg.sv
// Shared encodings and score helpers for the pong game-flow controller.
package pong_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned SCORE_BCD_W = 2 * BCD_DIGIT_W;
    localparam int unsigned SCORE_BIN_W = 7;
    localparam int unsigned SCORE_MAX   = 99;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_e;

    // Binary score after one point, saturating at the 2-digit display maximum.
    function automatic logic [SCORE_BIN_W-1:0] score_next(input logic [SCORE_BIN_W-1:0] b);
        return (b >= SCORE_BIN_W'(SCORE_MAX)) ? b : b + SCORE_BIN_W'(1);
    endfunction

endpackage

// File: rtl/pong_bcd_score.sv
// Two-digit BCD score counter with a parallel binary copy for the win compare.
module pong_bcd_score
    import pong_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   inc,
    output logic [SCORE_BCD_W-1:0] bcd,
    output logic [SCORE_BIN_W-1:0] bin
);

    logic [BCD_DIGIT_W-1:0] ones_q, ones_d;
    logic [BCD_DIGIT_W-1:0] tens_q, tens_d;
    logic [SCORE_BIN_W-1:0] bin_q, bin_d;
    logic                   at_max_c;

    assign at_max_c = (tens_q == BCD_DIGIT_W'(9)) && (ones_q == BCD_DIGIT_W'(9));

    // Ones wrap 9->0 with carry; the whole score holds once it reads 99.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        bin_d  = bin_q;
        if (clr) begin
            ones_d = '0;
            tens_d = '0;
            bin_d  = '0;
        end else if (inc && !at_max_c) begin
            bin_d = score_next(bin_q);
            if (ones_q == BCD_DIGIT_W'(9)) begin
                ones_d = '0;
                tens_d = tens_q + BCD_DIGIT_W'(1);
            end else begin
                ones_d = ones_q + BCD_DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ones_q <= '0;
            tens_q <= '0;
            bin_q  <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
            bin_q  <= bin_d;
        end
    end

    assign bcd = {tens_q, ones_q};
    assign bin = bin_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSM: new game, play, serve delay, game over; owns scores and winner.
// Optional PONG_SERVE_BTN_EN: serve waits for a start press after the serve delay.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 11,
    parameter int unsigned SERVE_FRAMES = 120,
    parameter int unsigned OVER_FRAMES  = 180,
    parameter int unsigned TMR_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       refresh_tick,
    input  logic       pts_1,
    input  logic       pts_2,
    output logic       gra_still,
    output logic [1:0] game_state,
    output logic [7:0] score1_bcd,
    output logic [7:0] score2_bcd,
    output logic [1:0] winner
);

    game_state_e            state_q, state_d;
    winner_e                winner_q, winner_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   start_q;
    logic                   gra_still_q, gra_still_d;
    logic                   start_rise_c;
    logic                   clr_c, inc1_c, inc2_c;
    logic [SCORE_BIN_W-1:0] bin1_c, bin2_c;

    assign start_rise_c = start & ~start_q;

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        timer_d  = timer_q;
        clr_c    = 1'b0;
        inc1_c   = 1'b0;
        inc2_c   = 1'b0;
        unique case (state_q)
            ST_NEWGAME: begin
                if (start_rise_c) begin
                    clr_c    = 1'b1;
                    winner_d = WIN_NONE;
                    state_d  = ST_NEWBALL;
                    timer_d  = TMR_W'(SERVE_FRAMES);
                end
            end
            // Player 1 has priority when both point strobes arrive together.
            ST_PLAY: begin
                if (pts_1) begin
                    inc1_c = 1'b1;
                    if (32'(score_next(bin1_c)) == WIN_SCORE) begin
                        winner_d = WIN_P1;
                        state_d  = ST_OVER;
                        timer_d  = TMR_W'(OVER_FRAMES);
                    end else begin
                        state_d = ST_NEWBALL;
                        timer_d = TMR_W'(SERVE_FRAMES);
                    end
                end else if (pts_2) begin
                    inc2_c = 1'b1;
                    if (32'(score_next(bin2_c)) == WIN_SCORE) begin
                        winner_d = WIN_P2;
                        state_d  = ST_OVER;
                        timer_d  = TMR_W'(OVER_FRAMES);
                    end else begin
                        state_d = ST_NEWBALL;
                        timer_d = TMR_W'(SERVE_FRAMES);
                    end
                end
            end
            ST_NEWBALL: begin
`ifdef PONG_SERVE_BTN_EN
                if (timer_q == '0) begin
                    if (start_rise_c) begin
                        state_d = ST_PLAY;
                    end
                end else if (refresh_tick) begin
                    timer_d = timer_q - TMR_W'(1);
                end
`else
                if (refresh_tick) begin
                    if (timer_q <= TMR_W'(1)) begin
                        timer_d = '0;
                        state_d = ST_PLAY;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
`endif
            end
            ST_OVER: begin
                if (refresh_tick) begin
                    if (timer_q <= TMR_W'(1)) begin
                        timer_d = '0;
                        state_d = ST_NEWGAME;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
            end
            default: state_d = ST_NEWGAME;
        endcase
        gra_still_d = (state_d != ST_PLAY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_NEWGAME;
            winner_q    <= WIN_NONE;
            timer_q     <= '0;
            start_q     <= 1'b0;
            gra_still_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            timer_q     <= timer_d;
            start_q     <= start;
            gra_still_q <= gra_still_d;
        end
    end

    pong_bcd_score u_score1 (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_c),
        .inc   (inc1_c),
        .bcd   (score1_bcd),
        .bin   (bin1_c)
    );

    pong_bcd_score u_score2 (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_c),
        .inc   (inc2_c),
        .bcd   (score2_bcd),
        .bin   (bin2_c)
    );

    assign gra_still  = gra_still_q;
    assign game_state = state_q;
    assign winner     = winner_q;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-flow controller for the two-player pong display. Sequences new game → play → serve delay → game over, drives `gra_still` into the graphics block, and accepts its `pts_1`/`pts_2` point strobes. Keeps two BCD scores for the text overlay and declares a winner at a configurable score. Sits between the input/keyboard logic and the graphics/text renderers, clocked with the pixel logic.

## Interface
Parameters:
- `WIN_SCORE`, default 11. Winning score, range 1–99, compared in binary.
- `SERVE_FRAMES`, default 120. Refresh ticks spent in NEWBALL (2 s at 60 Hz).
- `OVER_FRAMES`, default 180. Refresh ticks spent in OVER.
- `TMR_W`, default 8. Frame-timer width; must hold max(SERVE_FRAMES, OVER_FRAMES).

Ports:
- `clk`, in, 1. Single system clock.
- `reset`, in, 1. Asynchronous, active-low (0 = reset).
- `start`, in, 1. Serve/start button, level, already synchronous to `clk`.
- `refresh_tick`, in, 1. One-cycle strobe per frame.
- `pts_1`, in, 1. Player 1 scores; may stay high for many cycles.
- `pts_2`, in, 1. Player 2 scores; same behaviour as `pts_1`.
- `gra_still`, out, 1. Freeze and recentre the ball.
- `game_state`, out, 2. 0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER.
- `score1_bcd`, out, 8. Player 1 score, {tens, ones}.
- `score2_bcd`, out, 8. Player 2 score, {tens, ones}.
- `winner`, out, 2. 0 none, 1 player 1, 2 player 2.

## Operation
- States:
  - NEWGAME: `gra_still`=1. On `start` rising edge: clear scores and `winner`, go to NEWBALL, load timer.
  - PLAY: `gra_still`=0. On first cycle with `pts_1` or `pts_2` high: increment that score. If the new binary score equals WIN_SCORE, set `winner`, go to OVER and load the OVER timer. Otherwise go to NEWBALL and load the serve timer.
  - NEWBALL: `gra_still`=1. Timer decrements on `refresh_tick`. At 0, go to PLAY.
  - OVER: `gra_still`=1. Timer decrements on `refresh_tick`. At 0, go to NEWGAME. Scores and `winner` hold.
- `pts_*` is sampled only in PLAY. It is ignored in all other states, so a strobe held high during NEWBALL cannot double-count.
- `pts_1` and `pts_2` high in the same cycle: `pts_1` wins and `pts_2` is dropped.
- `start` edge-detected with a 1-cycle delay register. A held `start` does not restart from OVER→NEWGAME.
- `start` outside NEWGAME is ignored.
- Scores: 2-digit BCD. Ones digit wraps 9→0 and carries into tens. Tens saturates at 9 (99 max).
- Timer counts down. The exit decision is made on the tick at which the timer reads 1 and steps to 0. A timer loaded with 0 exits on the next `refresh_tick`.

## Timing
- Reset values: state NEWGAME, `gra_still`=1, `game_state`=0, scores 8'h00, `winner`=0, timer 0, start-delay register 0.
- All outputs are registered or decoded directly from registered state; no input-to-output combinational path.
- Point latency: `pts_*` seen high at edge N → score updated and `gra_still`=1 after edge N.
- Start latency: `start` 0→1 sampled at edge N → NEWBALL after edge N.
- Serve duration: exactly SERVE_FRAMES `refresh_tick`s after entry, then PLAY.
- Reset mid-operation: immediate return to reset values, regardless of state.

## Configuration
- `PONG_SERVE_BTN_EN`:
  - Defined: NEWBALL exits to PLAY only after the timer reaches 0 and a `start` rising edge occurs.
  - Undefined: serve is automatic at timer expiry; `start` is used only in NEWGAME.

## Structure
- `pong_pkg`: state encoding constants (`ST_NEWGAME`..`ST_OVER`), `winner` encodings, BCD digit width.
- Sub-module `pong_bcd_score`, instantiated twice. Ports: clk, reset, clr, inc, bcd[7:0], bin[6:0]. It supplies the binary value for the WIN_SCORE compare.
- FSM, frame timer and start edge detect live in the top module.

## Test plan
- Reset, then `start` pulse, then 120 ticks → `gra_still` 1→0 after exactly the 120th tick; `game_state`=1.
- In PLAY, hold `pts_2` high for 500 cycles → `score2_bcd`=8'h01 (single count), `game_state`=2.
- `pts_1` and `pts_2` high in the same PLAY cycle → `score1_bcd`+1, `score2_bcd` unchanged.
- With WIN_SCORE=11, drive 11 player-1 points → `score1_bcd`=8'h11, `winner`=1, state OVER; after 180 ticks state NEWGAME, scores held.
- Preload `score1_bcd` to 8'h09, then one point → 8'h10. With WIN_SCORE=99 reachable, saturation holds at 8'h99.
- Assert `reset`=0 during NEWBALL mid-timer → all outputs at reset values the same cycle.
- Build with `PONG_SERVE_BTN_EN` defined: state stays NEWBALL past 120 ticks until a `start` edge.
